// File: rtl/mcp_seq_ctrl.sv
// mcp_seq_ctrl: multicycle fetch/decode/execute/writeback sequencer for the MCP core.
// Adds a variable-latency MemReq/MemAck handshake, a retired-instruction counter and
// conditional branches evaluated on the latched flag register.
// Optional feature: define MCP_CTRL_TIMEOUT_EN to enable the memory-wait watchdog and
// the sticky FAULT state.
module mcp_seq_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Run,
    input  logic [1:0]       Op,
    input  logic [2:0]       Funct,
    input  logic [3:0]       Flags,
    input  logic             MemAck,
    output logic             MemReq,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic             WriteASrc,
    output logic             RegSrc,
    output logic [1:0]       WriteDSrc,
    output logic [1:0]       ResultSrc,
    output logic [2:0]       ALUControl,
    output logic [2:0]       ShiftType,
    output logic [3:0]       FlagReg,
    output logic [CNT_W-1:0] InstrCount,
    output logic             Busy,
    output logic             Fault
);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StDpEx,
        StShEx,
        StAluWb,
        StMemAdr,
        StMemRd,
        StMemWr,
        StBranch,
        StFault
    } state_e;

    state_e           state_q, state_d;
    state_e           retire_state;
    logic [3:0]       flag_q;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;
    logic             flag_en;
    logic             taken;

    // Where an instruction goes when it retires: Run is only looked at here.
    assign retire_state = Run ? StFetch : StIdle;

    // Branch condition on the latched flags {N,Z,C,V}.
    always_comb begin
        taken = 1'b0;
        case (Funct)
            3'b000:  taken = 1'b1;
            3'b001:  taken = flag_q[2];
            3'b010:  taken = ~flag_q[2];
            3'b011:  taken = flag_q[1];
            3'b100:  taken = ~flag_q[1];
            3'b101:  taken = flag_q[3];
            3'b110:  taken = ~flag_q[3];
            default: taken = 1'b0;
        endcase
    end

`ifdef MCP_CTRL_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WaitLast = ~TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] wait_cnt_q;
    logic                 in_mem;
    logic                 timeout;

    assign in_mem  = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    // The cycle that would make the count reach all-ones diverts to FAULT instead.
    assign timeout = in_mem && !MemAck && (wait_cnt_q == WaitLast);

    // Wait counter: cleared outside and on entry to each memory state.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wait_cnt_q <= '0;
        end else if (!in_mem || (state_d != state_q)) begin
            wait_cnt_q <= '0;
        end else if (!MemAck) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign Fault = (state_q == StFault);
`else
    assign Fault = 1'b0;
`endif

    // Next-state logic and Moore controls, with MemAck qualifying the write strobes.
    always_comb begin
        state_d    = state_q;
        MemReq     = 1'b0;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 1'b0;
        WriteASrc  = 1'b0;
        RegSrc     = 1'b0;
        WriteDSrc  = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 3'b000;
        ShiftType  = 3'b000;
        retire     = 1'b0;
        flag_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Run) state_d = StFetch;
            end
            StFetch: begin
                MemReq = 1'b1;
                AdrSrc = 1'b0;
                if (MemAck) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (Op)
                    2'b00:   state_d = StDpEx;
                    2'b01:   state_d = StMemAdr;
                    2'b10:   state_d = StBranch;
                    default: state_d = StShEx;
                endcase
            end
            StDpEx: begin
                ALUControl = Funct;
                ALUSrcB    = 1'b1;
                flag_en    = 1'b1;
                // CMP only updates flags, so it retires without a writeback.
                if (Funct == 3'b111) begin
                    retire  = 1'b1;
                    state_d = retire_state;
                end else begin
                    state_d = StAluWb;
                end
            end
            StShEx: begin
                ShiftType = Funct;
                flag_en   = 1'b1;
                state_d   = StAluWb;
            end
            StAluWb: begin
                RegWrite  = 1'b1;
                ResultSrc = 2'b00;
                retire    = 1'b1;
                state_d   = retire_state;
            end
            StMemAdr: begin
                ALUControl = 3'b000;
                ALUSrcB    = 1'b1;
                state_d    = Funct[0] ? StMemRd : StMemWr;
            end
            StMemRd: begin
                MemReq    = 1'b1;
                AdrSrc    = 1'b1;
                ResultSrc = 2'b01;
                if (MemAck) begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                    state_d  = retire_state;
                end
            end
            StMemWr: begin
                MemReq   = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (MemAck) begin
                    retire  = 1'b1;
                    state_d = retire_state;
                end
            end
            StBranch: begin
                if (taken) begin
                    PCWrite   = 1'b1;
                    ResultSrc = 2'b10;
                end
                retire  = 1'b1;
                state_d = retire_state;
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
`ifdef MCP_CTRL_TIMEOUT_EN
        if (timeout) state_d = StFault;
`endif
    end

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Flag latch and retired-instruction counter (wraps naturally).
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            flag_q <= 4'b0000;
            cnt_q  <= '0;
        end else begin
            if (flag_en) flag_q <= Flags;
            if (retire)  cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign FlagReg    = flag_q;
    assign InstrCount = cnt_q;
    assign Busy       = (state_q != StIdle);

endmodule
